// File: rtl/inst_load_ctrl_pkg.sv
// +--------------------------------------------------------------------+
// | inst_load_ctrl_pkg : state encodings and shared constants           |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
`default_nettype none

package inst_load_ctrl_pkg;

  typedef enum logic [2:0] {
    ILC_IDLE  = 3'd0,
    ILC_LOAD  = 3'd1,
    ILC_DRAIN = 3'd2,
    ILC_RUN   = 3'd3,
    ILC_ERR   = 3'd4
  } ilc_state_t;

  localparam int          ILC_CNT_WD    = 13;
  localparam logic [63:0] ILC_BASE_ADDR = 64'h0;

endpackage

`default_nettype wire

// File: rtl/inst_load_cksum.sv
// +--------------------------------------------------------------------+
// | inst_load_cksum : XOR accumulator and last-beat compare             |
// | Built only with INST_LOAD_CKSUM_EN.            Revision 1.0         |
// +--------------------------------------------------------------------+
`default_nettype none

`ifdef INST_LOAD_CKSUM_EN
module inst_load_cksum #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          i_clr,
  input  logic          i_wr,
  input  logic          i_last,
  input  logic [DW-1:0] i_data,
  input  logic [DW-1:0] i_cksum,
  output logic          o_bad
);

  logic [DW-1:0] r_acc;
  logic          r_bad;
  logic [DW-1:0] w_acc_nxt;

  assign w_acc_nxt = r_acc ^ i_data;

  // The mismatch verdict is latched on the last beat and held for the drain phase.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_acc <= '0;
      r_bad <= 1'b0;
    end else if (i_clr) begin
      r_acc <= '0;
      r_bad <= 1'b0;
    end else if (i_wr) begin
      r_acc <= w_acc_nxt;
      if (i_last) begin
        r_bad <= (w_acc_nxt != i_cksum);
      end
    end
  end

  assign o_bad = r_bad;

endmodule
`endif

`default_nettype wire

// File: rtl/inst_load_ctrl.sv
// +--------------------------------------------------------------------+
// | inst_load_ctrl : inst-SRAM ownership between loader and IF stage    |
// | Optional checksum via INST_LOAD_CKSUM_EN.      Revision 1.0         |
// +--------------------------------------------------------------------+
`default_nettype none

module inst_load_ctrl
  import inst_load_ctrl_pkg::*;
#(
  parameter int            AW        = 64,
  parameter int            DW        = 32,
  parameter logic [AW-1:0] BASE_ADDR = AW'(ILC_BASE_ADDR),
  parameter int            MAX_WORDS = 4096,
  parameter int            RUN_DELAY = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  load_start,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [DW-1:0]         ld_data,
  input  logic                  ld_last,
  input  logic                  if_en,
  input  logic [AW-1:0]         if_addr,
  output logic                  sram_en,
  output logic                  sram_wen,
  output logic [AW-1:0]         sram_addr,
  output logic [AW-1:0]         sram_waddr,
  output logic [DW-1:0]         sram_wdata,
  output logic                  cpu_run,
  output logic                  load_done,
  output logic                  load_err,
  output logic [ILC_CNT_WD-1:0] word_cnt
`ifdef INST_LOAD_CKSUM_EN
  ,
  input  logic [DW-1:0]         ld_cksum,
  output logic                  cksum_err
`endif
);

  localparam logic [ILC_CNT_WD-1:0] c_max      = ILC_CNT_WD'(MAX_WORDS);
  localparam logic [3:0]            c_dly_init = 4'(RUN_DELAY - 1);

  ilc_state_t            r_state;
  ilc_state_t            w_nxt;
  logic                  r_ld_ready;
  logic                  r_cpu_run;
  logic                  r_load_done;
  logic                  r_load_err;
  logic [ILC_CNT_WD-1:0] r_cnt;
  logic [AW-1:0]         r_waddr;
  logic [3:0]            r_dly;
  logic                  w_beat;
  logic                  w_full;
  logic                  w_wr;
  logic                  w_bad;

  assign w_beat = ld_valid & r_ld_ready;
  assign w_full = (r_cnt == c_max);
  // A beat that arrives with the image already at capacity is refused, not written.
  assign w_wr   = w_beat & ~w_full;

`ifdef INST_LOAD_CKSUM_EN
  logic r_cksum_err;

  inst_load_cksum #(
    .DW (DW)
  ) u_cksum (
    .clk     (clk),
    .resetn  (resetn),
    .i_clr   (load_start),
    .i_wr    (w_wr),
    .i_last  (ld_last),
    .i_data  (ld_data),
    .i_cksum (ld_cksum),
    .o_bad   (w_bad)
  );

  assign cksum_err = r_cksum_err;
`else
  assign w_bad = 1'b0;
`endif

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ILC_LOAD: begin
        if (w_beat) begin
          if (w_full) begin
            w_nxt = ILC_ERR;
          end else if (ld_last) begin
            w_nxt = ILC_DRAIN;
          end
        end
      end
      ILC_DRAIN: begin
        if (r_dly == '0) begin
          w_nxt = w_bad ? ILC_ERR : ILC_RUN;
        end
      end
      default: begin
        w_nxt = r_state;
      end
    endcase
    // Restart wins from every state; the current beat still completes above.
    if (load_start) begin
      w_nxt = ILC_LOAD;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ILC_IDLE;
      r_ld_ready  <= 1'b0;
      r_cpu_run   <= 1'b0;
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
      r_cnt       <= '0;
      r_waddr     <= '0;
      r_dly       <= '0;
`ifdef INST_LOAD_CKSUM_EN
      r_cksum_err <= 1'b0;
`endif
    end else begin
      r_state    <= w_nxt;
      r_ld_ready <= (w_nxt == ILC_LOAD);
      r_cpu_run  <= (w_nxt == ILC_RUN);

      if (load_start) begin
        r_cnt       <= '0;
        r_waddr     <= BASE_ADDR;
        r_load_done <= 1'b0;
        r_load_err  <= 1'b0;
`ifdef INST_LOAD_CKSUM_EN
        r_cksum_err <= 1'b0;
`endif
      end else begin
        if (w_wr) begin
          r_cnt   <= r_cnt + 1'b1;
          r_waddr <= r_waddr + AW'(4);
        end
        if ((w_nxt == ILC_RUN) && (r_state != ILC_RUN)) begin
          r_load_done <= 1'b1;
        end
        if ((w_nxt == ILC_ERR) && (r_state != ILC_ERR)) begin
          r_load_err <= 1'b1;
        end
`ifdef INST_LOAD_CKSUM_EN
        if ((r_state == ILC_DRAIN) && (w_nxt == ILC_ERR)) begin
          r_cksum_err <= 1'b1;
        end
`endif
      end

      if ((w_nxt == ILC_DRAIN) && (r_state != ILC_DRAIN)) begin
        r_dly <= c_dly_init;
      end else if (r_dly != '0) begin
        r_dly <= r_dly - 1'b1;
      end
    end
  end

  // IF owns the port only in RUN; the loader only ever writes in LOAD.
  assign ld_ready   = r_ld_ready;
  assign cpu_run    = r_cpu_run;
  assign load_done  = r_load_done;
  assign load_err   = r_load_err;
  assign word_cnt   = r_cnt;
  assign sram_wen   = w_wr;
  assign sram_en    = w_wr | (r_cpu_run & if_en);
  assign sram_addr  = r_cpu_run ? if_addr : '0;
  assign sram_waddr = w_wr ? r_waddr : '0;
  assign sram_wdata = w_wr ? ld_data : '0;

endmodule

`default_nettype wire

// File: tb/tb_inst_load_ctrl.sv
// +--------------------------------------------------------------------+
// | tb_inst_load_ctrl : scoreboard bench for inst_load_ctrl             |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_inst_load_ctrl;
  import inst_load_ctrl_pkg::*;

  localparam int            AW   = 64;
  localparam int            DW   = 32;
  localparam int            MAXW = 4;
  localparam int            RD   = 2;
  localparam logic [AW-1:0] BASE = 64'h0;

  logic                  clk        = 1'b0;
  logic                  resetn     = 1'b0;
  logic                  load_start = 1'b0;
  logic                  ld_valid   = 1'b0;
  logic                  ld_last    = 1'b0;
  logic                  if_en      = 1'b0;
  logic [DW-1:0]         ld_data    = '0;
  logic [AW-1:0]         if_addr    = '0;
  logic                  ld_ready;
  logic                  sram_en;
  logic                  sram_wen;
  logic [AW-1:0]         sram_addr;
  logic [AW-1:0]         sram_waddr;
  logic [DW-1:0]         sram_wdata;
  logic                  cpu_run;
  logic                  load_done;
  logic                  load_err;
  logic [ILC_CNT_WD-1:0] word_cnt;
`ifdef INST_LOAD_CKSUM_EN
  logic [DW-1:0]         ld_cksum = '0;
  logic                  cksum_err;
`endif

  always #5 clk = ~clk;

  inst_load_ctrl #(
    .AW        (AW),
    .DW        (DW),
    .BASE_ADDR (BASE),
    .MAX_WORDS (MAXW),
    .RUN_DELAY (RD)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .load_start (load_start),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .if_en      (if_en),
    .if_addr    (if_addr),
    .sram_en    (sram_en),
    .sram_wen   (sram_wen),
    .sram_addr  (sram_addr),
    .sram_waddr (sram_waddr),
    .sram_wdata (sram_wdata),
    .cpu_run    (cpu_run),
    .load_done  (load_done),
    .load_err   (load_err),
    .word_cnt   (word_cnt)
`ifdef INST_LOAD_CKSUM_EN
    ,
    .ld_cksum   (ld_cksum),
    .cksum_err  (cksum_err)
`endif
  );

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           exp_q[$];
  wr_t           mon_e;
  int            mdl_cnt     = 0;
  bit            mdl_loading = 0;
  bit            mdl_err     = 0;
  logic [DW-1:0] mdl_xor     = '0;
  bit            cks_corrupt = 0;
  logic [DW-1:0] cks_flip    = 32'h4;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Write scoreboard plus IF-grant monitor
  always @(negedge clk) begin
    if (sram_wen) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%0h data=%0h with nothing expected", sram_waddr, sram_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write_addr", sram_waddr, mon_e.a);
        chk("write_data", 64'(sram_wdata), 64'(mon_e.d));
        chk("write_en", 64'(sram_en), 64'd1);
      end
    end else if (sram_en || (cpu_run && if_en)) begin
      chk("if_grant_en", 64'(sram_en), 64'(cpu_run && if_en));
      if (cpu_run && if_en) chk("if_grant_addr", sram_addr, if_addr);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic mdl_restart();
    mdl_cnt     = 0;
    mdl_xor     = '0;
    mdl_loading = 1;
    mdl_err     = 0;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick(1);
    load_start = 1'b0;
    mdl_restart();
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic l, input bit with_start);
    bit acc = 0;
    if (mdl_cnt < MAXW) exp_q.push_back('{a: BASE + 64'(4 * mdl_cnt), d: d});
    ld_valid   = 1'b1;
    ld_data    = d;
    ld_last    = l;
    load_start = with_start;
    if_en      = 1'($urandom_range(0, 1));
    if_addr    = {$urandom, $urandom};
`ifdef INST_LOAD_CKSUM_EN
    ld_cksum   = cks_corrupt ? (mdl_xor ^ d ^ cks_flip) : (mdl_xor ^ d);
`endif
    for (int k = 0; k < 16 && !acc; k++) begin
      @(negedge clk);
      if (ld_ready) acc = 1;
      @(posedge clk);
      #1;
    end
    ld_valid   = 1'b0;
    ld_last    = 1'b0;
    load_start = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL beat_accept: ld_ready=0 for 16 cycles, required 1");
      mdl_loading = 0;
    end else if (with_start) begin
      mdl_restart();
    end else if (mdl_cnt == MAXW) begin
      mdl_loading = 0;
      mdl_err     = 1;
    end else begin
      mdl_cnt++;
      mdl_xor ^= d;
      if (l) mdl_loading = 0;
    end
  endtask

  task automatic expect_run();
    for (int i = 1; i <= RD + 1; i++) begin
      @(negedge clk);
      chk("cpu_run_timing", 64'(cpu_run), 64'(i == RD + 1));
    end
    @(posedge clk);
    #1;
    chk("load_done", 64'(load_done), 64'd1);
    chk("run_load_err", 64'(load_err), 64'd0);
    chk("run_word_cnt", 64'(word_cnt), 64'(mdl_cnt));
  endtask

  task automatic expect_err(input string nm);
    chk({nm, "_load_err"}, 64'(load_err), 64'd1);
    chk({nm, "_cpu_run"}, 64'(cpu_run), 64'd0);
    chk({nm, "_ld_ready"}, 64'(ld_ready), 64'd0);
    chk({nm, "_load_done"}, 64'(load_done), 64'd0);
  endtask

`ifdef INST_LOAD_CKSUM_EN
  task automatic expect_cks_err();
    for (int i = 1; i <= RD + 2; i++) begin
      @(negedge clk);
      chk("cks_cpu_run", 64'(cpu_run), 64'd0);
    end
    @(posedge clk);
    #1;
    expect_err("cks");
    chk("cksum_err", 64'(cksum_err), 64'd1);
  endtask
`endif

  task automatic chk_zero(input string p);
    chk({p, "_ld_ready"},   64'(ld_ready),   64'd0);
    chk({p, "_sram_en"},    64'(sram_en),    64'd0);
    chk({p, "_sram_wen"},   64'(sram_wen),   64'd0);
    chk({p, "_sram_addr"},  sram_addr,       64'd0);
    chk({p, "_sram_waddr"}, sram_waddr,      64'd0);
    chk({p, "_sram_wdata"}, 64'(sram_wdata), 64'd0);
    chk({p, "_cpu_run"},    64'(cpu_run),    64'd0);
    chk({p, "_load_done"},  64'(load_done),  64'd0);
    chk({p, "_load_err"},   64'(load_err),   64'd0);
    chk({p, "_word_cnt"},   64'(word_cnt),   64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int last_idx;

    // Reset with loader and IF active: every output must stay 0
    ld_valid = 1'b1;
    if_en    = 1'b1;
    if_addr  = 64'h40;
    tick(3);
    chk_zero("reset");
    ld_valid = 1'b0;
    if_en    = 1'b0;
    resetn   = 1'b1;
    tick(1);
    chk("idle_ld_ready", 64'(ld_ready), 64'd0);

    start_load();
    chk("load_ld_ready", 64'(ld_ready), 64'd1);
    chk("load_word_cnt", 64'(word_cnt), 64'd0);
    beat(32'h13, 1'b0, 1'b0);
    beat(32'h93, 1'b0, 1'b0);
    beat(32'h113, 1'b1, 1'b0);
    expect_run();

    // RUN: IF owns the port, loader is ignored
    if_en    = 1'b1;
    if_addr  = 64'h4;
    ld_valid = 1'b1;
    ld_data  = 32'hdead_beef;
    @(negedge clk);
    chk("run_sram_en", 64'(sram_en), 64'd1);
    chk("run_sram_addr", sram_addr, 64'h4);
    chk("run_sram_wen", 64'(sram_wen), 64'd0);
    chk("run_ld_ready", 64'(ld_ready), 64'd0);
    @(posedge clk);
    #1;
    ld_valid = 1'b0;

    // Restart from RUN
    load_start = 1'b1;
    @(negedge clk);
    chk("restart_cpu_run_same", 64'(cpu_run), 64'd1);
    @(posedge clk);
    #1;
    load_start = 1'b0;
    mdl_restart();
    @(negedge clk);
    chk("restart_cpu_run", 64'(cpu_run), 64'd0);
    chk("restart_load_done", 64'(load_done), 64'd0);
    chk("restart_ld_ready", 64'(ld_ready), 64'd1);
    chk("restart_word_cnt", 64'(word_cnt), 64'd0);
    @(posedge clk);
    #1;
    beat($urandom, 1'b0, 1'b0);
    beat($urandom, 1'b0, 1'b1);
    chk("beat_with_start_cnt", 64'(word_cnt), 64'd0);
    chk("beat_with_start_ready", 64'(ld_ready), 64'd1);
    beat($urandom, 1'b1, 1'b0);
    expect_run();

    // Overflow: capacity MAXW, one beat beyond it
    start_load();
    for (int i = 0; i < MAXW + 1; i++) beat($urandom, 1'b0, 1'b0);
    expect_err("ovf");
    chk("ovf_word_cnt", 64'(word_cnt), 64'(MAXW));
    tick(5);
    chk("ovf_hold_cpu_run", 64'(cpu_run), 64'd0);
    chk("ovf_hold_load_err", 64'(load_err), 64'd1);

    // Randomized images of varying length, last position and gaps
    for (int r = 0; r < 12; r++) begin
      start_load();
`ifdef INST_LOAD_CKSUM_EN
      cks_corrupt = ($urandom_range(0, 3) == 0);
      cks_flip    = $urandom | 32'h1;
`endif
      n        = $urandom_range(1, MAXW + 2);
      last_idx = $urandom_range(0, MAXW + 2);
      for (int i = 0; i < n && mdl_loading; i++) begin
        tick($urandom_range(0, 2));
        beat($urandom, 1'(i == last_idx), 1'b0);
      end
      if (mdl_err) begin
        expect_err("rnd_ovf");
        chk("rnd_ovf_cnt", 64'(word_cnt), 64'(MAXW));
      end else if (!mdl_loading) begin
        if (cks_corrupt) begin
`ifdef INST_LOAD_CKSUM_EN
          expect_cks_err();
`endif
        end else begin
          expect_run();
        end
      end else begin
        chk("rnd_still_loading", 64'(ld_ready), 64'd1);
        chk("rnd_partial_cnt", 64'(word_cnt), 64'(mdl_cnt));
      end
      cks_corrupt = 0;
    end

    // Async reset mid-load after two beats
    start_load();
    beat($urandom, 1'b0, 1'b0);
    beat($urandom, 1'b0, 1'b0);
    chk("pre_reset_cnt", 64'(word_cnt), 64'd2);
    #2;
    resetn   = 1'b0;
    ld_valid = 1'b1;
    #1;
    chk_zero("async_rst");
    @(posedge clk);
    #1;
    resetn = 1'b1;
    mdl_loading = 0;
    tick(3);
    chk("post_reset_ready", 64'(ld_ready), 64'd0);
    chk("post_reset_cnt", 64'(word_cnt), 64'd0);
    ld_valid = 1'b0;

`ifdef INST_LOAD_CKSUM_EN
    start_load();
    beat(32'h1, 1'b0, 1'b0);
    beat(32'h2, 1'b1, 1'b0);
    expect_run();
    chk("cks_ok_flag", 64'(cksum_err), 64'd0);
    start_load();
    cks_corrupt = 1;
    cks_flip    = 32'h4;
    beat(32'h1, 1'b0, 1'b0);
    beat(32'h2, 1'b1, 1'b0);
    expect_cks_err();
    cks_corrupt = 0;
`endif

    tick(2);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
